// File: rtl/uart_tx_queue_pkg.sv
// Shared UART constants, pacer state type and the frame-gap helper for the TX queue.
package uart_tx_queue_pkg;

    localparam int UART_FRAME_BITS = 11;
    localparam int UART_BAUD       = 115200;
    localparam int SYS_CLK_HZ      = 100_000_000;

    // Cycles covering one full frame, rounded up, plus a 50-cycle margin.
    function automatic int calcGapCycles(input int clkHz, input int baud, input int frameBits);
        longint num;
        num = longint'(clkHz) * longint'(frameBits);
        return int'((num + longint'(baud) - 64'sd1) / longint'(baud)) + 50;
    endfunction

    localparam int GAP_CYCLES_MIN = calcGapCycles(SYS_CLK_HZ, UART_BAUD, UART_FRAME_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } txState_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Producer-side handshake plus transmitter-side strobe/data and status of the TX queue.
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             wr_valid_i;
    logic [7:0]       wr_data_i;
    logic             wr_ready_o;
    logic             flush_i;
    logic             uart_wr_o;
    logic [7:0]       uart_dat_o;
    logic [LVL_W-1:0] level_o;
    logic             idle_o;

    modport slave (
        input  wr_valid_i, wr_data_i, flush_i,
        output wr_ready_o, uart_wr_o, uart_dat_o, level_o, idle_o
    );

    modport master (
        output wr_valid_i, wr_data_i, flush_i,
        input  wr_ready_o, uart_wr_o, uart_dat_o, level_o, idle_o
    );

endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Generic single-clock FIFO with registered occupancy and a synchronous clear that beats push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     sys_clk_i,
    input  logic                     sys_rstn_i,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_level == (AW+1)'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign o_level  = r_level;
    assign o_data   = r_mem[r_rdPtr];
    assign w_doPush = i_push && !o_full && !i_clear;
    assign w_doPop  = i_pop && !o_empty && !i_clear;

    always_ff @(posedge sys_clk_i) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers are exactly AW bits wide so they wrap on their own; clear equalises them.
    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (i_clear) begin
            r_rdPtr <= r_wrPtr;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and pacer feeding a UART transmitter that has no busy flag: strobes are
// spaced at least GAP_CYCLES apart so no write lands while a frame is still going out.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 9600,
    parameter int CNT_W      = 14
) (
    input  logic            sys_clk_i,
    input  logic            sys_rstn_i,
    uart_tx_queue_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    txState_e         r_state;
    txState_e         w_nextState;
    logic [CNT_W-1:0] r_gapCnt;
    logic             r_uartWr;
    logic [7:0]       r_uartDat;
    logic             w_pop;
    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .i_clear    (bus.flush_i),
        .i_push     (bus.wr_valid_i),
        .i_data     (bus.wr_data_i),
        .i_pop      (w_pop),
        .o_data     (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_level    (w_level)
    );

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Leaving GAP when the counter is about to hit zero lets the IDLE pop cycle
    // complete the spacing, so back-to-back strobes land exactly GAP_CYCLES apart.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (!w_empty && !bus.flush_i) w_nextState = GAP;
            GAP:  if (r_gapCnt == CNT_W'(1))    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_pop = (r_state == IDLE) && !w_empty && !bus.flush_i;
    end

    always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
        if (!sys_rstn_i) begin
            r_uartWr  <= 1'b0;
            r_uartDat <= 8'h00;
            r_gapCnt  <= '0;
        end else begin
            r_uartWr <= w_pop;
            if (w_pop) begin
                r_uartDat <= w_head;
                r_gapCnt  <= CNT_W'(GAP_CYCLES - 1);
            end else if (r_state == GAP) begin
                r_gapCnt <= r_gapCnt - 1'b1;
            end
        end
    end

    assign bus.wr_ready_o = !w_full;
    assign bus.uart_wr_o  = r_uartWr;
    assign bus.uart_dat_o = r_uartDat;
    assign bus.level_o    = w_level;
    assign bus.idle_o     = (w_level == '0) && (r_state == IDLE) && !r_uartWr;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomised bench for uart_tx_queue: a timing-rule model predicts strobes into a scoreboard
// that an independent monitor drains whenever the DUT strobes.
module tb_uart_tx_queue;

    localparam int DEPTH = 4;
    localparam int GAP   = 20;
    localparam int CNT_W = 14;

    typedef struct {
        logic [7:0] data;
        int         edgeN;
    } expStrobe_t;

    logic sys_clk_i  = 1'b0;
    logic sys_rstn_i = 1'b0;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus();

    uart_tx_queue #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP),
        .CNT_W      (CNT_W)
    ) dut (
        .sys_clk_i  (sys_clk_i),
        .sys_rstn_i (sys_rstn_i),
        .bus        (bus)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int checks = 0;
    int passes = 0;
    int edgeCnt = 0;

    logic [7:0] mQ[$];
    logic [7:0] prodQ[$];
    expStrobe_t expQ[$];
    int         mLast = -1000;
    logic [7:0] mDat = 8'h00;

    always @(posedge sys_clk_i) edgeCnt++;

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeCnt);
    endtask

    // The queue may only strobe a full gap after its previous strobe; state after edge edgeCnt.
    function automatic bit modelIdle();
        return (mQ.size() == 0) && (edgeCnt >= mLast + GAP - 1);
    endfunction

    task automatic checkOutput();
        compare("wr_ready", int'(bus.wr_ready_o), int'(mQ.size() != DEPTH));
        compare("level",    int'(bus.level_o),    mQ.size());
        compare("idle",     int'(bus.idle_o),     int'(modelIdle()));
        compare("uart_dat", int'(bus.uart_dat_o), int'(mDat));
    endtask

    task automatic applyStimulus(input bit valid, input logic [7:0] data, input bit flush,
                                 output bit accepted);
        int  n;
        bit  strobe;
        bus.wr_valid_i = valid;
        bus.wr_data_i  = data;
        bus.flush_i    = flush;
        n        = edgeCnt + 1;
        strobe   = (n >= mLast + GAP) && (mQ.size() > 0) && !flush;
        accepted = valid && (mQ.size() < DEPTH) && !flush;
        if (flush) mQ.delete();
        if (strobe) begin
            mDat  = mQ.pop_front();
            mLast = n;
            expQ.push_back('{data: mDat, edgeN: n});
        end
        if (accepted) mQ.push_back(data);
    endtask

    task automatic runCycle(input bit valid, input logic [7:0] data, input bit flush);
        bit acc;
        @(negedge sys_clk_i);
        checkOutput();
        applyStimulus(valid, data, flush, acc);
        if (acc && prodQ.size() > 0 && valid && data == prodQ[0]) void'(prodQ.pop_front());
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) runCycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic runProducer(input int budget);
        int k = 0;
        while (prodQ.size() > 0 && k < budget) begin
            runCycle(1'b1, prodQ[0], 1'b0);
            k++;
        end
        compare("producer_done", prodQ.size(), 0);
    endtask

    task automatic drain();
        int k = 0;
        while ((mQ.size() > 0 || expQ.size() > 0) && k < 400) begin
            runIdle(1);
            k++;
        end
        runIdle(GAP + 2);
        compare("drain_empty", expQ.size(), 0);
    endtask

    task automatic doReset();
        @(negedge sys_clk_i);
        checkOutput();
        #1;
        sys_rstn_i     = 1'b0;
        bus.wr_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        #1;
        compare("rst_uart_wr",  int'(bus.uart_wr_o),  0);
        compare("rst_uart_dat", int'(bus.uart_dat_o), 0);
        compare("rst_level",    int'(bus.level_o),    0);
        compare("rst_wr_ready", int'(bus.wr_ready_o), 1);
        compare("rst_idle",     int'(bus.idle_o),     1);
        mQ.delete();
        expQ.delete();
        mLast = -1000;
        mDat  = 8'h00;
        repeat (3) @(negedge sys_clk_i);
        sys_rstn_i = 1'b1;
    endtask

    // Monitor: every strobe must match the oldest prediction in data and edge.
    initial begin
        expStrobe_t e;
        forever begin
            @(negedge sys_clk_i);
            if (sys_rstn_i && bus.uart_wr_o === 1'b1) begin
                if (expQ.size() == 0) begin
                    compare("unexpected_strobe", int'(bus.uart_wr_o), 0);
                end else begin
                    e = expQ.pop_front();
                    compare("strobe_data", int'(bus.uart_dat_o), int'(e.data));
                    compare("strobe_edge", edgeCnt, e.edgeN);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = 8'h00;
        bus.flush_i    = 1'b0;
        sys_rstn_i     = 1'b0;
        #1;
        compare("init_level",    int'(bus.level_o),    0);
        compare("init_wr_ready", int'(bus.wr_ready_o), 1);
        compare("init_idle",     int'(bus.idle_o),     1);
        repeat (3) @(negedge sys_clk_i);
        sys_rstn_i = 1'b1;

        $display("[TB] quiet after reset");
        runIdle(10);

        $display("[TB] single byte");
        prodQ = '{8'h41};
        runProducer(5);
        drain();

        $display("[TB] three back-to-back bytes");
        prodQ = '{8'h48, 8'h69, 8'h0A};
        runProducer(10);
        drain();

        $display("[TB] six bytes against a full queue");
        prodQ = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        runProducer(200);
        drain();

        $display("[TB] flush during gap");
        prodQ = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        runProducer(10);
        runCycle(1'b0, 8'h00, 1'b1);
        drain();

        $display("[TB] reset mid-gap");
        prodQ = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
        runProducer(10);
        runIdle(1);
        compare("pre_reset_level", mQ.size(), 3);
        doReset();
        runIdle(30);

        $display("[TB] random traffic");
        for (int i = 0; i < 700; i++) begin
            runCycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 49) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
